// File: rtl/crc_serial_engine_pkg.sv
// ----------------------------------------------------------------------------
// crc_pkg
//   Shared types and constants for the serial CRC engine.
//   - state_t      : engine FSM states (IDLE waits for a word, BUSY folds it)
//   - presets      : POLY/INIT/REFLECT/XOR/RESIDUE sets for CCITT-FALSE,
//                    XMODEM and CRC-32 so instances can be configured by name
//   - reverse_bits : bit-reverses the low 'width' bits of a 32-bit value
// ----------------------------------------------------------------------------
package crc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // CRC-16/CCITT-FALSE
    localparam logic [15:0] CCITT_FALSE_POLY        = 16'h1021;
    localparam logic [15:0] CCITT_FALSE_INIT        = 16'hFFFF;
    localparam bit          CCITT_FALSE_REFLECT_IN  = 1'b0;
    localparam bit          CCITT_FALSE_REFLECT_OUT = 1'b0;
    localparam logic [15:0] CCITT_FALSE_XOR_OUT     = 16'h0000;
    localparam logic [15:0] CCITT_FALSE_RESIDUE     = 16'h0000;

    // CRC-16/XMODEM
    localparam logic [15:0] XMODEM_POLY        = 16'h1021;
    localparam logic [15:0] XMODEM_INIT        = 16'h0000;
    localparam bit          XMODEM_REFLECT_IN  = 1'b0;
    localparam bit          XMODEM_REFLECT_OUT = 1'b0;
    localparam logic [15:0] XMODEM_XOR_OUT     = 16'h0000;
    localparam logic [15:0] XMODEM_RESIDUE     = 16'h0000;

    // CRC-32 (IEEE 802.3). The residue is the raw MSB-first register value,
    // i.e. the bit-reverse of the familiar reflected residue 32'hDEBB20E3.
    localparam logic [31:0] CRC32_POLY        = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT        = 32'hFFFFFFFF;
    localparam bit          CRC32_REFLECT_IN  = 1'b1;
    localparam bit          CRC32_REFLECT_OUT = 1'b1;
    localparam logic [31:0] CRC32_XOR_OUT     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE     = 32'hC704DD7B;

    // Reverse the low 'width' bits of value; bits at and above 'width' return 0.
    function automatic logic [31:0] reverse_bits(input logic [31:0] value, input int width);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                result[i] = value[5'(width - 1 - i)];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/crc_serial_engine_if.sv
// ----------------------------------------------------------------------------
// crc_serial_engine_if
//   Word handshake and result bus of the serial CRC engine.
//   clear      : reload INIT, abort word in progress   (master -> slave)
//   write      : crc_in valid                           (master -> slave)
//   crc_in     : DATA_W-bit data word                   (master -> slave)
//   crc_accept : crc_in captured on this edge           (slave -> master)
//   crc_rdy    : engine idle, next write accepted       (slave -> master)
//   crc_out    : finished CRC, valid while crc_rdy      (slave -> master)
//   crc_ok     : raw register matches residue          (slave -> master)
// ----------------------------------------------------------------------------
interface crc_serial_engine_if #(
    parameter int WIDTH  = 16,
    parameter int DATA_W = 8
) ();
    logic              clear;
    logic              write;
    logic [DATA_W-1:0] crc_in;
    logic              crc_accept;
    logic              crc_rdy;
    logic [WIDTH-1:0]  crc_out;
    logic              crc_ok;

    modport master (
        output clear, write, crc_in,
        input  crc_accept, crc_rdy, crc_out, crc_ok
    );

    modport slave (
        input  clear, write, crc_in,
        output crc_accept, crc_rdy, crc_out, crc_ok
    );
endinterface

// File: rtl/crc_serial_engine_fold.sv
// ----------------------------------------------------------------------------
// crc_fold
//   Combinational MSB-first LFSR step: folds BPC data bits (data[BPC-1]
//   first) into a WIDTH-bit CRC register.
//   crc_cur  in  WIDTH  current register
//   data     in  BPC    bits to fold, MSB first
//   crc_next out WIDTH  register after BPC single-bit steps
// ----------------------------------------------------------------------------
module crc_fold #(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY = 16'h1021,
    parameter int              BPC   = 1
) (
    input  logic [WIDTH-1:0] crc_cur,
    input  logic [BPC-1:0]   data,
    output logic [WIDTH-1:0] crc_next
);
    logic [WIDTH-1:0] acc;
    logic             fb;

    // Unrolled chain of single-bit steps; the feedback bit decides whether
    // the polynomial is XORed into the shifted register.
    always_comb begin
        acc = crc_cur;
        fb  = 1'b0;
        for (int i = BPC - 1; i >= 0; i--) begin
            fb  = acc[WIDTH-1] ^ data[i];
            acc = {acc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        crc_next = acc;
    end
endmodule

// File: rtl/crc_serial_engine.sv
// ----------------------------------------------------------------------------
// crc_serial_engine
//   Parametrised serial CRC engine. Accepts DATA_W-bit words over a
//   write/accept/rdy handshake and folds BPC bits per clock into a WIDTH-bit
//   register. Input/output reflection and final XOR make it cover CCITT,
//   XMODEM and CRC-32.
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   bus  slave modport of crc_serial_engine_if (clear, write, crc_in,
//        crc_accept, crc_rdy, crc_out, crc_ok)
//   Optional feature macro: CRC_CHECK_EN drives crc_ok = (reg == RESIDUE);
//   without it crc_ok is tied low.
// ----------------------------------------------------------------------------
module crc_serial_engine
    import crc_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] POLY        = 16'h1021,
    parameter logic [WIDTH-1:0] INIT        = 16'hFFFF,
    parameter int               DATA_W      = 8,
    parameter int               BPC         = 1,
    parameter bit               REFLECT_IN  = 1'b0,
    parameter bit               REFLECT_OUT = 1'b0,
    parameter logic [WIDTH-1:0] XOR_OUT     = 16'h0000,
    parameter logic [WIDTH-1:0] RESIDUE     = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    crc_serial_engine_if.slave bus
);
    localparam int STEPS = DATA_W / BPC;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_load;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  crc_reg;
    logic [WIDTH-1:0]  crc_next;
    logic [WIDTH-1:0]  crc_view;
    logic              crc_rdy;
    logic              crc_accept;
    logic              last_step;

    assign last_step  = (cnt == CNT_W'(STEPS - 1));
    assign shift_load = REFLECT_IN ? DATA_W'(reverse_bits(32'(bus.crc_in), DATA_W))
                                   : bus.crc_in;

    crc_fold #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .BPC   (BPC)
    ) u_fold (
        .crc_cur  (crc_reg),
        .data     (shift_reg[DATA_W-1 -: BPC]),
        .crc_next (crc_next)
    );

    // State register; clear is handled through next_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake outputs. A word is taken only when idle and
    // not being cleared; reset also masks accept so it never pulses while
    // the capture would be discarded.
    always_comb begin
        next_state = state;
        crc_rdy    = (state == IDLE);
        crc_accept = 1'b0;
        case (state)
            IDLE: begin
                if (bus.write && !bus.clear && !rst) begin
                    crc_accept = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (bus.clear) begin
            next_state = IDLE;
        end
    end

    // Datapath: load the (optionally reflected) word on accept, then fold
    // BPC bits per clock from the top of the shift register.
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            crc_reg   <= INIT;
            shift_reg <= '0;
            cnt       <= '0;
        end else if (crc_accept) begin
            shift_reg <= shift_load;
            cnt       <= '0;
        end else if (state == BUSY) begin
            crc_reg   <= crc_next;
            shift_reg <= shift_reg << BPC;
            cnt       <= last_step ? '0 : cnt + 1'b1;
        end
    end

    assign crc_view       = REFLECT_OUT ? WIDTH'(reverse_bits(32'(crc_reg), WIDTH)) : crc_reg;
    assign bus.crc_out    = crc_view ^ XOR_OUT;
    assign bus.crc_rdy    = crc_rdy;
    assign bus.crc_accept = crc_accept;

`ifdef CRC_CHECK_EN
    assign bus.crc_ok = (crc_reg == RESIDUE);
`else
    // Feature disabled: the compare is masked to a constant and folds away.
    assign bus.crc_ok = 1'b0 && (crc_reg == RESIDUE);
`endif
endmodule

// File: tb/tb_crc_serial_engine.sv
// ----------------------------------------------------------------------------
// tb_crc_serial_engine
//   Directed bench for crc_serial_engine with three instances:
//   CCITT-FALSE (BPC=1), CRC-32 (BPC=8) and XMODEM (BPC=4), all fed the
//   "123456789" check string. Honours CRC_CHECK_EN for the crc_ok checks.
// ----------------------------------------------------------------------------
module tb_crc_serial_engine;
    import crc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   assert_count = 0;
    int   fail_count   = 0;

    logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

`ifdef CRC_CHECK_EN
    localparam logic EXP_OK = 1'b1;
`else
    localparam logic EXP_OK = 1'b0;
`endif

    always #5 clk = ~clk;

    crc_serial_engine_if #(.WIDTH(16), .DATA_W(8)) if_ccitt  ();
    crc_serial_engine_if #(.WIDTH(32), .DATA_W(8)) if_crc32  ();
    crc_serial_engine_if #(.WIDTH(16), .DATA_W(8)) if_xmodem ();

    crc_serial_engine #(
        .WIDTH(16), .POLY(CCITT_FALSE_POLY), .INIT(CCITT_FALSE_INIT), .DATA_W(8), .BPC(1),
        .REFLECT_IN(CCITT_FALSE_REFLECT_IN), .REFLECT_OUT(CCITT_FALSE_REFLECT_OUT),
        .XOR_OUT(CCITT_FALSE_XOR_OUT), .RESIDUE(CCITT_FALSE_RESIDUE)
    ) dut_ccitt (.clk(clk), .rst(rst), .bus(if_ccitt));

    crc_serial_engine #(
        .WIDTH(32), .POLY(CRC32_POLY), .INIT(CRC32_INIT), .DATA_W(8), .BPC(8),
        .REFLECT_IN(CRC32_REFLECT_IN), .REFLECT_OUT(CRC32_REFLECT_OUT),
        .XOR_OUT(CRC32_XOR_OUT), .RESIDUE(CRC32_RESIDUE)
    ) dut_crc32 (.clk(clk), .rst(rst), .bus(if_crc32));

    crc_serial_engine #(
        .WIDTH(16), .POLY(XMODEM_POLY), .INIT(XMODEM_INIT), .DATA_W(8), .BPC(4),
        .REFLECT_IN(XMODEM_REFLECT_IN), .REFLECT_OUT(XMODEM_REFLECT_OUT),
        .XOR_OUT(XMODEM_XOR_OUT), .RESIDUE(XMODEM_RESIDUE)
    ) dut_xmodem (.clk(clk), .rst(rst), .bus(if_xmodem));

    // Hard stop in case a handshake never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Selector helpers: 0 = CCITT, 1 = CRC-32, 2 = XMODEM.
    task automatic set_inputs(input int which, input logic wr, input logic [7:0] data, input logic clr);
        case (which)
            0:       begin if_ccitt.write  = wr; if_ccitt.crc_in  = data; if_ccitt.clear  = clr; end
            1:       begin if_crc32.write  = wr; if_crc32.crc_in  = data; if_crc32.clear  = clr; end
            default: begin if_xmodem.write = wr; if_xmodem.crc_in = data; if_xmodem.clear = clr; end
        endcase
    endtask

    function automatic logic get_rdy(input int which);
        case (which)
            0:       return if_ccitt.crc_rdy;
            1:       return if_crc32.crc_rdy;
            default: return if_xmodem.crc_rdy;
        endcase
    endfunction

    function automatic logic get_accept(input int which);
        case (which)
            0:       return if_ccitt.crc_accept;
            1:       return if_crc32.crc_accept;
            default: return if_xmodem.crc_accept;
        endcase
    endfunction

    // Present one word, note whether it was accepted, then count clocks
    // until the engine is ready again (bounded).
    task automatic applyStimulus(input int which, input logic [7:0] w, output int busy, output logic acc);
        @(negedge clk);
        set_inputs(which, 1'b1, w, 1'b0);
        #1;
        acc = get_accept(which);
        @(posedge clk);
        #1;
        set_inputs(which, 1'b0, 8'h00, 1'b0);
        busy = 0;
        while (!get_rdy(which) && busy < 40) begin
            @(posedge clk);
            #1;
            busy++;
        end
    endtask

    // Pulse clear for one clock on the selected engine.
    task automatic pulse_clear(input int which);
        @(negedge clk);
        set_inputs(which, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        set_inputs(which, 1'b0, 8'h00, 1'b0);
    endtask

    // Reset state of all three engines: ready, no accept, crc_out = f(INIT).
    task automatic test_reset;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) set_inputs(k, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        assert_count++;
        if (if_ccitt.crc_rdy !== 1'b1 || if_ccitt.crc_accept !== 1'b0 || if_ccitt.crc_out !== 16'hFFFF) begin
            fail_count++;
            $display("[TB] FAIL reset_ccitt: rdy=%b acc=%b out=%h, want rdy=1 acc=0 out=ffff",
                     if_ccitt.crc_rdy, if_ccitt.crc_accept, if_ccitt.crc_out);
        end
        assert_count++;
        if (if_crc32.crc_rdy !== 1'b1 || if_crc32.crc_out !== 32'h00000000) begin
            fail_count++;
            $display("[TB] FAIL reset_crc32: rdy=%b out=%h, want rdy=1 out=00000000",
                     if_crc32.crc_rdy, if_crc32.crc_out);
        end
        assert_count++;
        if (if_xmodem.crc_rdy !== 1'b1 || if_xmodem.crc_out !== 16'h0000 || if_ccitt.crc_ok !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL reset_xmodem: rdy=%b out=%h ccitt_ok=%b, want rdy=1 out=0000 ok=0",
                     if_xmodem.crc_rdy, if_xmodem.crc_out, if_ccitt.crc_ok);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // CCITT-FALSE, one bit per clock: 8 busy clocks per word, check 29B1.
    task automatic test_ccitt(input string tag);
        int   busy;
        logic acc;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, msg[i], busy, acc);
            assert_count++;
            if (acc !== 1'b1 || busy !== 8) begin
                fail_count++;
                $display("[TB] FAIL %s_word%0d: accept=%b busy=%0d, want accept=1 busy=8", tag, i, acc, busy);
            end
        end
        assert_count++;
        if (if_ccitt.crc_out !== 16'h29B1) begin
            fail_count++;
            $display("[TB] FAIL %s_crc: got %h, want 29b1", tag, if_ccitt.crc_out);
        end
    endtask

    // CRC-32 with byte-wide folding: each word busy exactly one clock.
    task automatic test_crc32;
        int   busy;
        logic acc;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, msg[i], busy, acc);
            assert_count++;
            if (acc !== 1'b1 || busy !== 1) begin
                fail_count++;
                $display("[TB] FAIL crc32_word%0d: accept=%b busy=%0d, want accept=1 busy=1", i, acc, busy);
            end
        end
        assert_count++;
        if (if_crc32.crc_out !== 32'hCBF43926) begin
            fail_count++;
            $display("[TB] FAIL crc32_crc: got %h, want cbf43926", if_crc32.crc_out);
        end
    endtask

    // XMODEM with write held high: one accept every 3 clocks, exactly 9.
    task automatic test_back_to_back;
        int idx      = 0;
        int accepts  = 0;
        int last_cyc = -1;
        int gap_err  = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            set_inputs(2, (idx < 9), msg[(idx < 9) ? idx : 0], 1'b0);
            #1;
            if (if_xmodem.crc_accept === 1'b1) begin
                if (last_cyc >= 0 && (cyc - last_cyc) != 3) gap_err++;
                last_cyc = cyc;
                idx++;
                accepts++;
            end
        end
        set_inputs(2, 1'b0, 8'h00, 1'b0);
        assert_count++;
        if (accepts !== 9 || gap_err !== 0) begin
            fail_count++;
            $display("[TB] FAIL b2b_accepts: accepts=%0d bad_gaps=%0d, want 9 and 0", accepts, gap_err);
        end
        assert_count++;
        if (if_xmodem.crc_rdy !== 1'b1 || if_xmodem.crc_out !== 16'h31C3) begin
            fail_count++;
            $display("[TB] FAIL b2b_crc: rdy=%b out=%h, want rdy=1 out=31c3", if_xmodem.crc_rdy, if_xmodem.crc_out);
        end
    endtask

    // Clear mid-word and while idle (with write high): never accepted,
    // register returns to INIT, then the full message still gives 29B1.
    task automatic test_clear;
        int   busy;
        logic acc;
        for (int i = 0; i < 5; i++) applyStimulus(0, msg[i], busy, acc);
        @(negedge clk);
        set_inputs(0, 1'b1, msg[5], 1'b0);
        @(posedge clk);
        #1;
        set_inputs(0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        set_inputs(0, 1'b1, msg[6], 1'b1);
        #1;
        assert_count++;
        if (if_ccitt.crc_accept !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL clear_busy_accept: got %b, want 0", if_ccitt.crc_accept);
        end
        @(posedge clk);
        #1;
        set_inputs(0, 1'b0, 8'h00, 1'b0);
        assert_count++;
        if (if_ccitt.crc_rdy !== 1'b1 || if_ccitt.crc_out !== 16'hFFFF) begin
            fail_count++;
            $display("[TB] FAIL clear_state: rdy=%b out=%h, want rdy=1 out=ffff", if_ccitt.crc_rdy, if_ccitt.crc_out);
        end
        @(negedge clk);
        set_inputs(0, 1'b1, msg[0], 1'b1);
        #1;
        assert_count++;
        if (if_ccitt.crc_accept !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL clear_idle_accept: got %b, want 0", if_ccitt.crc_accept);
        end
        @(posedge clk);
        #1;
        set_inputs(0, 1'b0, 8'h00, 1'b0);
        assert_count++;
        if (if_ccitt.crc_rdy !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL clear_idle_rdy: got %b, want 1", if_ccitt.crc_rdy);
        end
        test_ccitt("clear_rerun");
    endtask

    // Reset in the middle of a word behaves like power-up.
    task automatic test_reset_mid_word;
        int   busy;
        logic acc;
        for (int i = 0; i < 3; i++) applyStimulus(0, msg[i], busy, acc);
        @(negedge clk);
        set_inputs(0, 1'b1, msg[3], 1'b0);
        @(posedge clk);
        #1;
        set_inputs(0, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        assert_count++;
        if (if_ccitt.crc_rdy !== 1'b1 || if_ccitt.crc_accept !== 1'b0 || if_ccitt.crc_out !== 16'hFFFF) begin
            fail_count++;
            $display("[TB] FAIL rst_mid_word: rdy=%b acc=%b out=%h, want rdy=1 acc=0 out=ffff",
                     if_ccitt.crc_rdy, if_ccitt.crc_accept, if_ccitt.crc_out);
        end
        @(negedge clk);
        rst = 1'b0;
        test_ccitt("rst_rerun");
    endtask

    // Message followed by its own CRC leaves the register at the residue;
    // a flipped last bit leaves exactly POLY behind instead.
    task automatic test_residue;
        int         busy;
        logic       acc;
        logic [7:0] tail [2];
        pulse_clear(0);
        for (int i = 0; i < 9; i++) applyStimulus(0, msg[i], busy, acc);
        tail = '{8'h29, 8'hB1};
        for (int i = 0; i < 2; i++) applyStimulus(0, tail[i], busy, acc);
        assert_count++;
        if (if_ccitt.crc_ok !== EXP_OK || if_ccitt.crc_out !== 16'h0000) begin
            fail_count++;
            $display("[TB] FAIL residue_good: ok=%b out=%h, want ok=%b out=0000", if_ccitt.crc_ok, if_ccitt.crc_out, EXP_OK);
        end
        pulse_clear(0);
        for (int i = 0; i < 9; i++) applyStimulus(0, msg[i], busy, acc);
        tail = '{8'h29, 8'hB0};
        for (int i = 0; i < 2; i++) applyStimulus(0, tail[i], busy, acc);
        assert_count++;
        if (if_ccitt.crc_ok !== 1'b0 || if_ccitt.crc_out !== 16'h1021) begin
            fail_count++;
            $display("[TB] FAIL residue_bad: ok=%b out=%h, want ok=0 out=1021", if_ccitt.crc_ok, if_ccitt.crc_out);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) set_inputs(k, 1'b0, 8'h00, 1'b0);
        $display("[TB] starting crc_serial_engine tests");
        test_reset;
        test_ccitt("ccitt");
        test_crc32;
        test_back_to_back;
        test_clear;
        test_reset_mid_word;
        test_residue;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
